// File: rtl/uart_ctrl_param.sv
// uart_ctrl_param: 16550-style UART register controller with parametrised
// RX/TX byte FIFOs, bus register map and a maskable level interrupt.
// Optional feature: define UART_LOOPBACK_EN to add the MCR register (index 10)
// whose bit 4 loops every TX pop back into the RX FIFO.
module uart_ctrl_param #(
  parameter int          FIFO_AW      = 9,
  parameter int          ADDR_W       = 6,
  parameter logic [31:0] RD_EMPTY_VAL = 32'h8000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] addr_32b_i,
  input  logic        wren_i,
  input  logic        rden_i,
  input  logic [31:0] din_32b_i,
  output logic        dout_32b_valid_o,
  output logic [31:0] dout_32b_o,
  output logic        interrupt_o,
  input  logic [7:0]  din_8b_i,
  input  logic        din_valid_i,
  output logic [7:0]  dout_8b_o,
  output logic        dout_valid_o,
  input  logic        tx_busy_i
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] FULL_CNT = (FIFO_AW+1)'(DEPTH);
  localparam logic [ADDR_W-3:0] IDX_RBR  = (ADDR_W-2)'(0);
  localparam logic [ADDR_W-3:0] IDX_THR  = (ADDR_W-2)'(1);
  localparam logic [ADDR_W-3:0] IDX_IER  = (ADDR_W-2)'(4);
  localparam logic [ADDR_W-3:0] IDX_IIR  = (ADDR_W-2)'(5);
  localparam logic [ADDR_W-3:0] IDX_FCR  = (ADDR_W-2)'(6);
  localparam logic [ADDR_W-3:0] IDX_LSR  = (ADDR_W-2)'(8);
  localparam logic [ADDR_W-3:0] IDX_FCNT = (ADDR_W-2)'(9);
  localparam logic [ADDR_W-3:0] IDX_MCR  = (ADDR_W-2)'(10);

  // FIFO storage and bookkeeping
  logic [7:0]         r_rx_mem [0:DEPTH-1];
  logic [7:0]         r_tx_mem [0:DEPTH-1];
  logic [FIFO_AW-1:0] r_rx_wp, r_rx_rp, r_tx_wp, r_tx_rp;
  logic [FIFO_AW:0]   r_rx_cnt, r_tx_cnt;

  // control / status registers
  logic [2:0]  r_ier;
  logic [1:0]  r_rxthr;
  logic        r_ovr;
  logic        r_ack;
  logic [31:0] r_dout;
  logic        r_irq;
  logic        r_tx_popped;
  logic        r_tx_valid;
  logic [7:0]  r_tx_byte;

  logic [ADDR_W-3:0] w_idx;
  logic w_rd, w_wr, w_rbr_rd, w_lsr_rd, w_thr_wr, w_ier_wr, w_fcr_wr, w_mcr_wr;
  logic w_rx_flush, w_tx_flush;
  logic w_rx_empty, w_rx_full, w_tx_empty, w_tx_full;
  logic w_tx_pop, w_tx_push, w_rx_pop, w_rx_push, w_ovr_set;
  logic w_rx_in_valid;
  logic [7:0]  w_rx_in_byte, w_tx_head, w_rx_head;
  logic [10:0] w_rx_cnt11, w_tx_cnt11, w_thr11;
  logic w_rxt;
  logic [3:0]  w_iir;
  logic [31:0] w_rdata;
  logic w_loop;
  logic w_unused;

  assign w_unused = ^{addr_32b_i[31:ADDR_W], addr_32b_i[1:0], din_32b_i[31:8]};

`ifdef UART_LOOPBACK_EN
  logic r_loop;
  assign w_loop = r_loop;
  // MCR loopback bit
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)         r_loop <= 1'b0;
    else if (w_mcr_wr) r_loop <= din_32b_i[4];
  end
`else
  assign w_loop = 1'b0;
`endif

  // bus decode: a read wins over a simultaneous write
  assign w_idx      = addr_32b_i[ADDR_W-1:2];
  assign w_rd       = rden_i;
  assign w_wr       = wren_i & ~rden_i;
  assign w_rbr_rd   = w_rd & (w_idx == IDX_RBR);
  assign w_lsr_rd   = w_rd & (w_idx == IDX_LSR);
  assign w_thr_wr   = w_wr & (w_idx == IDX_THR);
  assign w_ier_wr   = w_wr & (w_idx == IDX_IER);
  assign w_fcr_wr   = w_wr & (w_idx == IDX_FCR);
  assign w_mcr_wr   = w_wr & (w_idx == IDX_MCR);
  assign w_rx_flush = w_fcr_wr & din_32b_i[1];
  assign w_tx_flush = w_fcr_wr & din_32b_i[2];

  assign w_rx_empty = (r_rx_cnt == '0);
  assign w_rx_full  = (r_rx_cnt == FULL_CNT);
  assign w_tx_empty = (r_tx_cnt == '0);
  assign w_tx_full  = (r_tx_cnt == FULL_CNT);
  assign w_tx_head  = r_tx_mem[r_tx_rp];
  assign w_rx_head  = r_rx_mem[r_rx_rp];

  // TX drain: one pop at most every other cycle; a flush cancels it
  assign w_tx_pop  = ~w_tx_empty & (w_loop | ~tx_busy_i) & ~r_tx_popped & ~w_tx_flush;
  assign w_tx_push = w_thr_wr & (~w_tx_full | w_tx_pop);

  // RX source is either the serialiser or the looped-back TX byte
  assign w_rx_in_valid = w_loop ? w_tx_pop  : din_valid_i;
  assign w_rx_in_byte  = w_loop ? w_tx_head : din_8b_i;
  assign w_rx_pop  = w_rbr_rd & ~w_rx_empty;
  assign w_rx_push = w_rx_in_valid & (~w_rx_full | w_rx_pop) & ~w_rx_flush;
  assign w_ovr_set = w_rx_in_valid & w_rx_full & ~w_rx_pop & ~w_rx_flush;

  // interrupt sources
  assign w_rx_cnt11 = 11'(r_rx_cnt);
  assign w_tx_cnt11 = 11'(r_tx_cnt);
  assign w_thr11    = 11'd1 << r_rxthr;
  assign w_rxt      = (w_rx_cnt11 >= w_thr11);
  assign w_iir = (r_ovr & r_ier[2])      ? 4'd12 :
                 (w_rxt & r_ier[0])      ? 4'd8  :
                 (w_tx_empty & r_ier[1]) ? 4'd4  : 4'd0;

  // read-data mux
  always_comb begin
    w_rdata = 32'h0;
    case (w_idx)
      IDX_RBR:  w_rdata = w_rx_empty ? RD_EMPTY_VAL : {24'h0, w_rx_head};
      IDX_IER:  w_rdata = {29'h0, r_ier};
      IDX_IIR:  w_rdata = {28'h0, w_iir};
      IDX_LSR:  w_rdata = {26'h0, w_tx_empty, w_tx_full, 2'b00, r_ovr, ~w_rx_empty};
      IDX_FCNT: w_rdata = {5'h0, w_tx_cnt11, 5'h0, w_rx_cnt11};
`ifdef UART_LOOPBACK_EN
      IDX_MCR:  w_rdata = {27'h0, r_loop, 4'h0};
`endif
      default:  w_rdata = 32'h0;
    endcase
  end

  // FIFO RAM writes
  always_ff @(posedge clk_i) begin
    if (w_rx_push) r_rx_mem[r_rx_wp] <= w_rx_in_byte;
    if (w_tx_push) r_tx_mem[r_tx_wp] <= din_32b_i[7:0];
  end

  // RX pointers and count; flush wins over push/pop
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i || w_rx_flush) begin
      r_rx_wp <= '0; r_rx_rp <= '0; r_rx_cnt <= '0;
    end else begin
      if (w_rx_push) r_rx_wp <= r_rx_wp + FIFO_AW'(1);
      if (w_rx_pop)  r_rx_rp <= r_rx_rp + FIFO_AW'(1);
      if (w_rx_push & ~w_rx_pop)      r_rx_cnt <= r_rx_cnt + (FIFO_AW+1)'(1);
      else if (~w_rx_push & w_rx_pop) r_rx_cnt <= r_rx_cnt - (FIFO_AW+1)'(1);
    end
  end

  // TX pointers and count; flush wins over push/pop
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i || w_tx_flush) begin
      r_tx_wp <= '0; r_tx_rp <= '0; r_tx_cnt <= '0;
    end else begin
      if (w_tx_push) r_tx_wp <= r_tx_wp + FIFO_AW'(1);
      if (w_tx_pop)  r_tx_rp <= r_tx_rp + FIFO_AW'(1);
      if (w_tx_push & ~w_tx_pop)      r_tx_cnt <= r_tx_cnt + (FIFO_AW+1)'(1);
      else if (~w_tx_push & w_tx_pop) r_tx_cnt <= r_tx_cnt - (FIFO_AW+1)'(1);
    end
  end

  // config registers, sticky overrun, bus response and interrupt
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_ier <= '0; r_rxthr <= '0; r_ovr <= 1'b0;
      r_ack <= 1'b0; r_dout <= '0; r_irq <= 1'b0;
    end else begin
      if (w_ier_wr) r_ier   <= din_32b_i[2:0];
      if (w_fcr_wr) r_rxthr <= din_32b_i[7:6];
      r_ovr <= w_ovr_set | (r_ovr & ~w_lsr_rd);
      r_ack <= rden_i | wren_i;
      if (w_rd) r_dout <= w_rdata;
      r_irq <= (w_rxt & r_ier[0]) | (w_tx_empty & r_ier[1]) | (r_ovr & r_ier[2]);
    end
  end

  // TX serialiser strobe
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_tx_popped <= 1'b0; r_tx_valid <= 1'b0; r_tx_byte <= '0;
    end else begin
      r_tx_popped <= w_tx_pop;
      r_tx_valid  <= w_tx_pop & ~w_loop;
      if (w_tx_pop & ~w_loop) r_tx_byte <= w_tx_head;
    end
  end

  assign dout_32b_valid_o = r_ack;
  assign dout_32b_o       = r_dout;
  assign interrupt_o      = r_irq;
  assign dout_8b_o        = r_tx_byte;
  assign dout_valid_o     = r_tx_valid;

endmodule

// File: tb/tb_uart_ctrl_param.sv
// Bench for uart_ctrl_param (FIFO depth 8): queue-based reference model checked
// every cycle, plus literal expectations on register reads.
module tb_uart_ctrl_param;
  localparam int AW    = 3;
  localparam int DEPTH = 1 << AW;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic [31:0] addr_32b_i = '0;
  logic        wren_i = 1'b0, rden_i = 1'b0;
  logic [31:0] din_32b_i = '0;
  logic        dout_32b_valid_o;
  logic [31:0] dout_32b_o;
  logic        interrupt_o;
  logic [7:0]  din_8b_i = '0;
  logic        din_valid_i = 1'b0;
  logic [7:0]  dout_8b_o;
  logic        dout_valid_o;
  logic        tx_busy_i = 1'b0;

  uart_ctrl_param #(.FIFO_AW(AW), .ADDR_W(6), .RD_EMPTY_VAL(32'h8000_0000)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .addr_32b_i(addr_32b_i), .wren_i(wren_i),
    .rden_i(rden_i), .din_32b_i(din_32b_i), .dout_32b_valid_o(dout_32b_valid_o),
    .dout_32b_o(dout_32b_o), .interrupt_o(interrupt_o), .din_8b_i(din_8b_i),
    .din_valid_i(din_valid_i), .dout_8b_o(dout_8b_o), .dout_valid_o(dout_valid_o),
    .tx_busy_i(tx_busy_i)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  byte unsigned m_rx[$];
  byte unsigned m_tx[$];
  bit [2:0]  m_ier = '0;
  bit [1:0]  m_thr = '0;
  bit        m_ovr = 1'b0, m_popped = 1'b0, m_loop = 1'b0;
  logic        e_ack = 1'b0, e_irq = 1'b0, e_txv = 1'b0;
  logic [31:0] e_dout = '0;
  logic [7:0]  e_txb = '0;
  int          mi;
  bit          m_rd, m_wr, m_flrx, m_fltx, m_rxt, m_txe, m_pop, m_inv, m_ovrset, m_lin;
  byte unsigned m_b, m_inb, m_lb;
  logic [31:0] m_rdata;
  int          m_iir;

  always @(posedge clk_i) begin
    if (rst_i) begin
      m_rx.delete(); m_tx.delete();
      m_ier = '0; m_thr = '0; m_ovr = 0; m_popped = 0; m_loop = 0;
      e_ack = 0; e_irq = 0; e_txv = 0; e_dout = '0; e_txb = '0;
    end else begin
      mi     = int'(addr_32b_i[5:2]);
      m_rd   = rden_i;
      m_wr   = wren_i && !rden_i;
      m_flrx = m_wr && mi == 6 && din_32b_i[1];
      m_fltx = m_wr && mi == 6 && din_32b_i[2];
      m_rxt  = m_rx.size() >= (1 << m_thr);
      m_txe  = m_tx.size() == 0;
      m_iir  = (m_ovr && m_ier[2]) ? 12 : (m_rxt && m_ier[0]) ? 8 : (m_txe && m_ier[1]) ? 4 : 0;
      case (mi)
        0:  m_rdata = (m_rx.size() > 0) ? 32'(m_rx[0]) : 32'h8000_0000;
        4:  m_rdata = 32'(m_ier);
        5:  m_rdata = 32'(m_iir);
        8:  m_rdata = (m_txe ? 32'h20 : 0) | ((m_tx.size() == DEPTH) ? 32'h10 : 0) |
                      (m_ovr ? 32'h2 : 0) | ((m_rx.size() > 0) ? 32'h1 : 0);
        9:  m_rdata = 32'(m_rx.size()) | (32'(m_tx.size()) << 16);
`ifdef UART_LOOPBACK_EN
        10: m_rdata = m_loop ? 32'h10 : 32'h0;
`endif
        default: m_rdata = 32'h0;
      endcase
      e_irq = (m_rxt && m_ier[0]) || (m_txe && m_ier[1]) || (m_ovr && m_ier[2]);
      // TX drain
      m_pop = m_tx.size() > 0 && (m_loop || !tx_busy_i) && !m_popped && !m_fltx;
      m_popped = m_pop;
      e_txv = 0; m_lin = 0; m_lb = 0;
      if (m_pop) begin
        m_b = m_tx.pop_front();
        if (m_loop) begin m_lin = 1; m_lb = m_b; end
        else begin e_txv = 1; e_txb = m_b; end
      end
      if (m_wr && mi == 1 && m_tx.size() < DEPTH) m_tx.push_back(din_32b_i[7:0]);
      if (m_fltx) m_tx.delete();
      // RX
      m_inv = m_loop ? m_lin : din_valid_i;
      m_inb = m_loop ? m_lb  : din_8b_i;
      m_ovrset = 0;
      if (m_flrx) m_rx.delete();
      else begin
        if (m_rd && mi == 0 && m_rx.size() > 0) m_b = m_rx.pop_front();
        if (m_inv) begin
          if (m_rx.size() < DEPTH) m_rx.push_back(m_inb);
          else m_ovrset = 1;
        end
      end
      m_ovr = (m_rd && mi == 8) ? m_ovrset : (m_ovr | m_ovrset);
      if (m_wr && mi == 4) m_ier = din_32b_i[2:0];
      if (m_wr && mi == 6) m_thr = din_32b_i[7:6];
`ifdef UART_LOOPBACK_EN
      if (m_wr && mi == 10) m_loop = din_32b_i[4];
`endif
      e_ack = rden_i || wren_i;
      if (rden_i) e_dout = m_rdata;
    end
  end

  // ---------------- per-cycle compare ----------------
  bit  cmp_en = 1'b0;
  int  cyc = 0, last_tx = -100;
  byte unsigned tx_seen[$];

  always @(negedge clk_i) begin
    cyc++;
    if (cmp_en) begin
      chk("ack", 32'(dout_32b_valid_o), 32'(e_ack));
      chk("rdata", dout_32b_o, e_dout);
      chk("irq", 32'(interrupt_o), 32'(e_irq));
      chk("tx_valid", 32'(dout_valid_o), 32'(e_txv));
      if (e_txv) chk("tx_byte", 32'(dout_8b_o), 32'(e_txb));
      if (dout_valid_o === 1'b1) begin
        chk("tx_gap_ok", 32'((cyc - last_tx) >= 2), 32'd1);
        last_tx = cyc;
        tx_seen.push_back(dout_8b_o);
      end
    end
  end

  // ---------------- stimulus helpers (enter/leave at a negedge) ----------------
  task automatic bus_rd(input int idx, input logic [31:0] lit);
    rden_i = 1; addr_32b_i = 32'(idx) << 2;
    @(negedge clk_i);
    rden_i = 0;
    chk($sformatf("rd_idx%0d", idx), dout_32b_o, lit);
  endtask

  task automatic bus_wr(input int idx, input logic [31:0] d);
    wren_i = 1; addr_32b_i = 32'(idx) << 2; din_32b_i = d;
    @(negedge clk_i);
    wren_i = 0;
  endtask

  task automatic push_rx(input logic [7:0] b);
    din_valid_i = 1; din_8b_i = b;
    @(negedge clk_i);
    din_valid_i = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  int base;

  initial begin
    #1 rst_i = 1;
    #1 cmp_en = 1;
    @(negedge clk_i);
    chk("rst_ack", 32'(dout_32b_valid_o), 32'd0);
    chk("rst_irq", 32'(interrupt_o), 32'd0);
    chk("rst_txv", 32'(dout_valid_o), 32'd0);
    idle(1);
    rst_i = 0;
    idle(1);

    // empty RBR and reset LSR
    bus_rd(0, 32'h8000_0000);
    bus_rd(8, 32'h0000_0020);

    // TX drain of three bytes
    base = tx_seen.size();
    bus_wr(1, 32'h41); bus_wr(1, 32'h42); bus_wr(1, 32'h43);
    idle(8);
    chk("tx_count", 32'(tx_seen.size() - base), 32'd3);
    if (tx_seen.size() - base == 3) begin
      chk("tx0", 32'(tx_seen[base]),   32'h41);
      chk("tx1", 32'(tx_seen[base+1]), 32'h42);
      chk("tx2", 32'(tx_seen[base+2]), 32'h43);
    end
    bus_rd(8, 32'h0000_0020);

    // RX threshold of 8
    bus_wr(6, 32'hC0); bus_wr(4, 32'h1);
    for (int i = 0; i < 7; i++) push_rx(8'(8'h10 + i));
    idle(2);
    chk("irq_below_thr", 32'(interrupt_o), 32'd0);
    push_rx(8'h17);
    idle(1);
    chk("irq_at_thr", 32'(interrupt_o), 32'd1);
    bus_rd(5, 32'd8);
    bus_rd(0, 32'h0000_0010);
    idle(1);
    chk("irq_after_pop", 32'(interrupt_o), 32'd0);
    bus_wr(6, 32'h02);

    // overrun with one byte held in TX
    bus_wr(4, 32'h4);
    tx_busy_i = 1;
    bus_wr(1, 32'h99);
    for (int i = 0; i < 9; i++) push_rx(8'(8'h20 + i));
    bus_rd(9, 32'h0001_0008);
    chk("irq_ovr", 32'(interrupt_o), 32'd1);
    bus_rd(5, 32'd12);
    bus_rd(8, 32'h0000_0003);
    bus_rd(8, 32'h0000_0001);
    // push + pop while full: count unchanged, no overrun
    rden_i = 1; addr_32b_i = 32'h0; din_valid_i = 1; din_8b_i = 8'h77;
    @(negedge clk_i);
    rden_i = 0; din_valid_i = 0;
    chk("full_pop_head", dout_32b_o, 32'h0000_0020);
    bus_rd(9, 32'h0001_0008);
    bus_rd(8, 32'h0000_0001);

    // TX flush while busy
    bus_wr(1, 32'hA1); bus_wr(1, 32'hA2); bus_wr(1, 32'hA3);
    bus_rd(9, 32'h0004_0008);
    bus_wr(6, 32'h04);
    bus_rd(9, 32'h0000_0008);
    base = tx_seen.size();
    tx_busy_i = 0;
    idle(4);
    chk("no_tx_after_flush", 32'(tx_seen.size() - base), 32'd0);
    // RX flush beats a same-cycle push
    wren_i = 1; addr_32b_i = 32'(6) << 2; din_32b_i = 32'h02;
    din_valid_i = 1; din_8b_i = 8'h55;
    @(negedge clk_i);
    wren_i = 0; din_valid_i = 0;
    bus_rd(9, 32'h0000_0000);

    // read wins over simultaneous write
    rden_i = 1; wren_i = 1; addr_32b_i = 32'(4) << 2; din_32b_i = 32'h7;
    @(negedge clk_i);
    rden_i = 0; wren_i = 0;
    chk("rd_wr_prio", dout_32b_o, 32'h4);
    bus_rd(4, 32'h4);

    // unmapped indices
    bus_wr(3, 32'hFF);
    bus_rd(3, 32'h0);
    bus_rd(2, 32'h0);
`ifndef UART_LOOPBACK_EN
    bus_wr(10, 32'h10);
    bus_rd(10, 32'h0);
`endif

    // TX-empty interrupt
    bus_wr(4, 32'h2);
    idle(2);
    chk("irq_txe", 32'(interrupt_o), 32'd1);
    bus_rd(5, 32'd4);
    bus_wr(4, 32'h0);
    idle(2);
    chk("irq_off", 32'(interrupt_o), 32'd0);

`ifdef UART_LOOPBACK_EN
    tx_busy_i = 1;
    bus_wr(10, 32'h10);
    bus_rd(10, 32'h10);
    base = tx_seen.size();
    bus_wr(1, 32'h5A);
    idle(4);
    chk("loop_no_tx", 32'(tx_seen.size() - base), 32'd0);
    bus_rd(0, 32'h0000_005A);
    push_rx(8'h33);
    bus_rd(9, 32'h0);
    tx_busy_i = 0;
`endif

    idle(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_ctrl_param.md
Name: uart_ctrl_param

Overview:
Parametrised, second-generation UART register controller for the timelyRV peripheral bus. It holds RX and TX byte FIFOs of configurable depth and exposes a 16550-style register map (RBR/THR/IER/IIR/FCR/LSR/FCNT). It generates a maskable, level-sensitive interrupt from RX-threshold, TX-empty and RX-overrun conditions. It sits between the 32-bit peripheral bus and the UART rx/tx serialiser cores.

Parameters:
FIFO_AW, 9, log2 of FIFO depth per direction (depth = 2^FIFO_AW; legal range 2..10).
ADDR_W, 6, number of bus address bits decoded; register index = addr_32b_i[ADDR_W-1:2].
RD_EMPTY_VAL, 32'h8000_0000, data returned when RBR is read with the RX FIFO empty.

Ports:
clk_i  in  1  system clock
rst_i  in  1  asynchronous active-high reset
addr_32b_i  in  32  bus byte address
wren_i  in  1  bus write strobe, one cycle per access
rden_i  in  1  bus read strobe, one cycle per access
din_32b_i  in  32  bus write data
dout_32b_valid_o  out  1  read-data / write-done pulse
dout_32b_o  out  32  read data
interrupt_o  out  1  level interrupt
din_8b_i  in  8  byte from rx serialiser
din_valid_i  in  1  rx byte strobe
dout_8b_o  out  8  byte to tx serialiser
dout_valid_o  out  1  tx byte strobe
tx_busy_i  in  1  tx serialiser busy

Behaviour:
- Reset: rst_i is asynchronous and active-high. While rst_i is high, all outputs read 0, both FIFOs are empty, IER=0, FCR threshold=0, and the LSR sticky bits are 0.
- Register map (index : function):
  - 0 RBR (R): pop the RX FIFO.
  - 1 THR (W): push din[7:0] to the TX FIFO.
  - 4 IER (R/W): bits [2:0]. Bit 0 enables the RX-threshold interrupt, bit 1 the TX-empty interrupt, bit 2 the overrun interrupt.
  - 5 IIR (R): bits [3:0].
  - 6 FCR (W):
    - Bits [7:6] set the RX threshold: 0→1 byte, 1→2, 2→4, 3→8.
    - Bit 2 flushes the TX FIFO; bit 1 flushes the RX FIFO. Flush bits are self-clearing.
  - 8 LSR (R): bit 5 TX empty, bit 4 TX full, bit 1 overrun (sticky), bit 0 RX not empty.
  - 9 FCNT (R): [10:0] RX count, [26:16] TX count.
  - Unmapped addresses read 0; writes to them are ignored.
- Bus access latency:
  - Every rden_i or wren_i produces exactly one dout_32b_valid_o pulse, in the next cycle. dout_32b_o is valid in that same cycle.
  - dout_32b_o holds its value until the next read; it is not cleared after the pulse.
  - rden_i and wren_i asserted together: the read takes priority and the write is dropped.
- RBR read:
  - FIFO not empty: returns {24'b0, head byte}; the pop happens in the same cycle the data is returned.
  - FIFO empty: returns RD_EMPTY_VAL with no pop.
- THR write with the TX FIFO full: byte is dropped and the access is still acknowledged.
- LSR read clears the overrun bit. If an overrun happens in the same cycle, the bit stays set.
- RX push:
  - din_valid_i with the FIFO full drops the byte and sets overrun.
  - A push and a pop in the same cycle keep the count unchanged, including when the FIFO is full.
  - An FCR RX flush beats a push or pop in the same cycle: the FIFO ends empty.
- TX drain:
  - When the TX FIFO is not empty, tx_busy_i=0 and dout_valid_o was 0 in the previous cycle: pop one byte, driving dout_valid_o=1 with dout_8b_o equal to the byte for one cycle.
  - Minimum spacing between tx strobes is 2 cycles.
  - A TX flush cancels a pending pop.
- Interrupt sources:
  - RXT = rx_count >= threshold.
  - TXE = tx empty.
  - OVR = overrun bit set.
  - interrupt_o = (RXT & IER0) | (TXE & IER1) | (OVR & IER2), registered (1-cycle latency).
- IIR priority: 12 = OVR, else 8 = RXT, else 4 = TXE, else 0. Only enabled sources are reported.
- FIFOs: inferred RAM plus wrap-around pointers, with a count of FIFO_AW+1 bits (full = 2^FIFO_AW). Pointers wrap modulo depth.

Optional Feature:
- Macro: UART_LOOPBACK_EN.
- When defined:
  - Register index 10 is MCR (R/W). Bit 4 is loopback.
  - With loopback=1, each TX pop is pushed into the RX FIFO instead of being driven out: dout_valid_o stays 0 and tx_busy_i is ignored.
  - din_valid_i is ignored while loopback=1.
  - Overrun rules apply to the looped-back pushes.
- When undefined: index 10 reads 0 and its writes are ignored, and the block has no loopback path.

Test Plan:
- Reset, then read RBR → 0x8000_0000 one cycle later. Read LSR → 0x20.
- Write THR with 0x41, 0x42, 0x43, tx_busy_i=0 → three dout_valid_o pulses carrying 0x41, 0x42, 0x43, each at least 2 cycles apart. LSR bit 5 returns to 1 afterwards.
- FCR=0xC0, IER=1, push 7 RX bytes → interrupt_o stays 0. Push an 8th → interrupt_o=1 one cycle later and IIR=8. One RBR read → interrupt_o=0.
- FIFO_AW=2: push 5 RX bytes → FCNT[10:0]=4, IIR=12 with IER=4. LSR read → 0x03; a second LSR read → 0x01.
- Fill TX to 4 with tx_busy_i=1, then write FCR=0x04 → FCNT[26:16]=0, no dout_valid_o. A same-cycle din_valid_i plus RX flush → RX count 0.
- With UART_LOOPBACK_EN defined: MCR=0x10, write THR 0x5A → dout_valid_o stays 0 and RBR read returns 0x0000_005A.
